// File: rtl/stopwatch_display_if.sv
// Bus between the stopwatch counter block and the multiplexed 6-digit display.
// There is no flow control on this bus: the master drives mode and time fields
// continuously, and the display samples them every clk. There is no valid/ready
// pair. The display drives segments, decimal point and digit enables back.
interface stopwatch_display_if;
    logic [1:0] state;
    logic [7:0] ms;
    logic [7:0] s;
    logic [7:0] m;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    modport master (output state, ms, s, m, input seg, dp, an);
    modport slave  (input state, ms, s, m, output seg, dp, an);
endinterface

// File: rtl/stopwatch_display.sv
// Six-digit multiplexed display for an mm.ss.hh stopwatch. The time fields
// arrive from another clock domain. They are accepted only when they hold the
// same value on two consecutive samples. A lap snapshot can freeze the display
// while the count keeps running underneath.
module stopwatch_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_display_if.slave  bus
);

    localparam int         CW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [1:0] ST_LAP = 2'b10;

    logic [23:0]   in_now;
    logic [23:0]   stage;
    logic [23:0]   live;
    logic [23:0]   hold;
    logic [1:0]    prev_state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic          lap_entry;
    logic [23:0]   shown;
    logic [7:0]    field;
    logic [3:0]    digit;
    logic          dash;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [5:0]    an_next;

    assign in_now    = {bus.m, bus.s, bus.ms};
    assign lap_entry = (bus.state == ST_LAP) && (prev_state != ST_LAP);

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Two-sample agreement filter: torn multi-bit updates never reach live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
            live  <= '0;
        end else begin
            stage <= in_now;
            if (stage == in_now) begin
                live <= in_now;
            end
        end
    end

    // Lap snapshot taken on entry to lap mode. It stores the pre-load live value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= 2'b00;
            hold       <= '0;
        end else begin
            prev_state <= bus.state;
            if (lap_entry) begin
                hold <= live;
            end
        end
    end

    // Scan timer: each digit stays enabled for SCAN_DIV clocks, then the index advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Choose the value on show, pick the field and digit for the current index, and encode it.
    // On the lap-entry cycle the snapshot is not loaded yet, so live is shown directly.
    always_comb begin
        shown = live;
        if (bus.state == ST_LAP) begin
            shown = lap_entry ? live : hold;
        end
        case (idx[2:1])
            2'd0:    field = shown[7:0];
            2'd1:    field = shown[15:8];
            default: field = shown[23:16];
        endcase
        dash     = (field > 8'd99);
        digit    = idx[0] ? 4'(field / 8'd10) : 4'(field % 8'd10);
        seg_next = dash ? 7'b0111111 : seg_of(digit);
        an_next  = ~(6'b000001 << idx);
        dp_next  = !((idx == 3'd2) || (idx == 3'd4));
    end

    // Registered display outputs, blanked while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
            bus.an  <= 6'b111111;
        end else begin
            bus.seg <= seg_next;
            bus.dp  <= dp_next;
            bus.an  <= an_next;
        end
    end

endmodule
